// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: W-bit shift history with fill tracking, Mealy/Moore match flags
// and a saturating match counter. Overlapping or non-overlapping detection is a parameter.
module seq_detect_fsm #(
    parameter int unsigned W       = 4,
    parameter logic [W-1:0] PATTERN = W'(4'b1011),
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     x,
    output logic [W-1:0]             y,
    output logic [$clog2(W+1)-1:0]   fill,
    output logic                     z_mealy,
    output logic                     z_moore,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat
);

    localparam int unsigned FW = $clog2(W + 1);

    logic [W-1:0]     y_q, y_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             z_moore_q, z_moore_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     window;
    logic             hit;

    // Candidate window includes the bit being sampled now.
    always_comb begin
        window = {y_q[W-2:0], x};
        hit    = en & ~clr & (fill_q >= FW'(W - 1)) & (window == PATTERN);
    end

    // Next-state: clear wins over enable; non-overlap restarts fill on a hit.
    always_comb begin
        y_d       = y_q;
        fill_d    = fill_q;
        z_moore_d = hit;
        cnt_d     = cnt_q;
        if (clr) begin
            y_d       = '0;
            fill_d    = '0;
            z_moore_d = 1'b0;
            cnt_d     = '0;
        end else if (en) begin
            y_d = window;
            if (fill_q == FW'(W)) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FW'(1);
            end
            if (hit) begin
                if (!OVERLAP) begin
                    fill_d = '0;
                end
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            fill_q    <= '0;
            z_moore_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            y_q       <= y_d;
            fill_q    <= fill_d;
            z_moore_q <= z_moore_d;
            cnt_q     <= cnt_d;
        end
    end

    assign y         = y_q;
    assign fill      = fill_q;
    assign z_mealy   = hit;
    assign z_moore   = z_moore_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three instances (overlap, non-overlap, saturating 1111 detector)
// checked against fixed scenarios and a queue-based reference model under random stimulus.
module tb_seq_detect_fsm;

    logic clk, rst_n, en, clr, x;

    logic [3:0] y_a, y_b, y_c;
    logic [2:0] fill_a, fill_b, fill_c;
    logic       zme_a, zme_b, zme_c, zmo_a, zmo_b, zmo_c, sat_a, sat_b, sat_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    seq_detect_fsm #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .y(y_a), .fill(fill_a),
        .z_mealy(zme_a), .z_moore(zmo_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
    seq_detect_fsm #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .y(y_b), .fill(fill_b),
        .z_mealy(zme_b), .z_moore(zmo_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
    seq_detect_fsm #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .y(y_c), .fill(fill_c),
        .z_mealy(zme_c), .z_moore(zmo_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

    logic [3:0] y_o[3];
    logic [2:0] fill_o[3];
    logic       mealy_o[3], moore_o[3], sat_o[3];
    logic [7:0] cnt_o[3];
    assign y_o[0] = y_a;  assign y_o[1] = y_b;  assign y_o[2] = y_c;
    assign fill_o[0] = fill_a;  assign fill_o[1] = fill_b;  assign fill_o[2] = fill_c;
    assign mealy_o[0] = zme_a;  assign mealy_o[1] = zme_b;  assign mealy_o[2] = zme_c;
    assign moore_o[0] = zmo_a;  assign moore_o[1] = zmo_b;  assign moore_o[2] = zmo_c;
    assign sat_o[0] = sat_a;  assign sat_o[1] = sat_b;  assign sat_o[2] = sat_c;
    assign cnt_o[0] = cnt_a;  assign cnt_o[1] = cnt_b;  assign cnt_o[2] = {6'b0, cnt_c};

    int checks = 0;
    int errors = 0;

    // Reference model: bit history since reset/clear, fresh-bit count, match count.
    bit         hq[$];
    int         avail[3];
    int         cnt_m[3];
    bit         moore_m[3];
    logic [3:0] pat[3]  = '{4'b1011, 4'b1011, 4'b1111};
    bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};
    int         cmax[3] = '{255, 255, 3};
    bit         obs_mealy[3], exp_mealy[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_y();
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (hq.size() > i) v[i] = hq[hq.size() - 1 - i];
        end
        return v;
    endfunction

    function automatic bit m_hit(int k, bit e, bit c, bit xx);
        logic [3:0] v, w;
        if (!e || c || avail[k] < 3) return 1'b0;
        v = m_y();
        w = {v[2:0], xx};
        return w == pat[k];
    endfunction

    task automatic m_reset();
        hq.delete();
        for (int k = 0; k < 3; k++) begin
            avail[k] = 0; cnt_m[k] = 0; moore_m[k] = 1'b0;
        end
    endtask

    task automatic m_step(bit e, bit c, bit xx);
        bit h[3];
        for (int k = 0; k < 3; k++) h[k] = m_hit(k, e, c, xx);
        if (c) begin
            m_reset();
        end else if (e) begin
            hq.push_back(xx);
            if (hq.size() > 8) void'(hq.pop_front());
            for (int k = 0; k < 3; k++) begin
                moore_m[k] = h[k];
                if (h[k] && !ovl[k]) avail[k] = 0;
                else avail[k] = (avail[k] + 1 > 4) ? 4 : avail[k] + 1;
                if (h[k] && cnt_m[k] < cmax[k]) cnt_m[k]++;
            end
        end else begin
            for (int k = 0; k < 3; k++) moore_m[k] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, capture Mealy before the edge, sample registers after it.
    task automatic tick(input bit e, input bit c, input bit xx);
        @(negedge clk);
        en = e; clr = c; x = xx;
        #1;
        for (int k = 0; k < 3; k++) begin
            obs_mealy[k] = mealy_o[k];
            exp_mealy[k] = m_hit(k, e, c, xx);
        end
        @(posedge clk);
        m_step(e, c, xx);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; x = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({y_o[k], fill_o[k], mealy_o[k], moore_o[k], cnt_o[k], sat_o[k]} !== '0) begin
                errors++;
                $display("FAIL reset[%0d] got y=%b fill=%0d zme=%b zmo=%b cnt=%0d sat=%b expected all 0",
                         k, y_o[k], fill_o[k], mealy_o[k], moore_o[k], cnt_o[k], sat_o[k]);
            end
        end
        @(negedge clk);
        en = 1'b0; x = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_match();
        bit s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, s[i]);
            checks++;
            if (obs_mealy[0] !== (i == 3)) begin
                errors++;
                $display("FAIL single_mealy bit %0d got %b expected %b", i + 1, obs_mealy[0], i == 3);
            end
        end
        checks++;
        if (moore_o[0] !== 1'b1 || cnt_o[0] !== 8'd1 || y_o[0] !== 4'b1011) begin
            errors++;
            $display("FAIL single_after got zmo=%b cnt=%0d y=%b expected 1 1 1011", moore_o[0], cnt_o[0], y_o[0]);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (moore_o[0] !== 1'b0 || cnt_o[0] !== 8'd1) begin
            errors++;
            $display("FAIL single_moore_drop got zmo=%b cnt=%0d expected 0 1", moore_o[0], cnt_o[0]);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] ma, mb;
        s = 7'b1011011; ma = '0; mb = '0;
        tick(1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 7; p++) begin
            tick(1'b1, 1'b0, s[6 - p]);
            ma[p] = obs_mealy[0];
            mb[p] = obs_mealy[1];
        end
        checks++;
        if (ma !== 7'b1001000 || cnt_o[0] !== 8'd2 || fill_o[0] !== 3'd4) begin
            errors++;
            $display("FAIL overlap_on got hits=%b cnt=%0d fill=%0d expected 1001000 2 4", ma, cnt_o[0], fill_o[0]);
        end
        checks++;
        if (mb !== 7'b0001000 || cnt_o[1] !== 8'd1 || fill_o[1] !== 3'd3) begin
            errors++;
            $display("FAIL overlap_off got hits=%b cnt=%0d fill=%0d expected 0001000 1 3", mb, cnt_o[1], fill_o[1]);
        end
    endtask

    task automatic test_enable_gap();
        int pulses;
        pulses = 0;
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            tick(1'b0, 1'b0, g[0]);
            pulses += int'(obs_mealy[0]);
            checks++;
            if (y_o[0] !== 4'b0010 || fill_o[0] !== 3'd2 || moore_o[0] !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold cyc %0d got y=%b fill=%0d zmo=%b expected 0010 2 0",
                         g, y_o[0], fill_o[0], moore_o[0]);
            end
        end
        tick(1'b1, 1'b0, 1'b1);
        pulses += int'(obs_mealy[0]);
        tick(1'b1, 1'b0, 1'b1);
        pulses += int'(obs_mealy[0]);
        checks++;
        if (pulses != 1 || obs_mealy[0] !== 1'b1 || cnt_o[0] !== 8'd1 || y_o[0] !== 4'b1011) begin
            errors++;
            $display("FAIL gap_match got pulses=%0d last=%b cnt=%0d y=%b expected 1 1 1 1011",
                     pulses, obs_mealy[0], cnt_o[0], y_o[0]);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            exp_cnt = (i <= 3) ? 0 : ((i - 3 > 3) ? 3 : i - 3);
            checks++;
            if (cnt_o[2] !== 8'(exp_cnt) || sat_o[2] !== (exp_cnt == 3) || moore_o[2] !== (i >= 4)) begin
                errors++;
                $display("FAIL sat_one %0d got cnt=%0d sat=%b zmo=%b expected %0d %b %b",
                         i, cnt_o[2], sat_o[2], moore_o[2], exp_cnt, exp_cnt == 3, i >= 4);
            end
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_mealy[2] !== 1'b0 || {y_o[2], fill_o[2], moore_o[2], cnt_o[2], sat_o[2]} !== '0) begin
            errors++;
            $display("FAIL sat_clear got zme=%b y=%b fill=%0d zmo=%b cnt=%0d sat=%b expected all 0",
                     obs_mealy[2], y_o[2], fill_o[2], moore_o[2], cnt_o[2], sat_o[2]);
        end
    endtask

    task automatic test_async_reset();
        bit s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (y_o[0] !== 4'b0000 || fill_o[0] !== 3'd0) begin
            errors++;
            $display("FAIL async_immediate got y=%b fill=%0d expected 0000 0", y_o[0], fill_o[0]);
        end
        m_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, s[i]);
            checks++;
            if (obs_mealy[0] !== (i == 3)) begin
                errors++;
                $display("FAIL async_post bit %0d got %b expected %b", i + 1, obs_mealy[0], i == 3);
            end
        end
        checks++;
        if (cnt_o[0] !== 8'd1) begin
            errors++;
            $display("FAIL async_cnt got %0d expected 1", cnt_o[0]);
        end
    endtask

    task automatic test_random();
        bit e, c, xx;
        for (int n = 0; n < 2000; n++) begin
            e  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 39) == 0);
            xx = 1'($urandom_range(0, 1));
            tick(e, c, xx);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs_mealy[k] !== exp_mealy[k] || y_o[k] !== m_y() || fill_o[k] !== 3'(avail[k]) ||
                    moore_o[k] !== moore_m[k] || cnt_o[k] !== 8'(cnt_m[k]) ||
                    sat_o[k] !== (cnt_m[k] == cmax[k])) begin
                    errors++;
                    $display("FAIL rnd[%0d] cyc %0d got zme=%b y=%b fill=%0d zmo=%b cnt=%0d sat=%b expected %b %b %0d %b %0d %b",
                             k, n, obs_mealy[k], y_o[k], fill_o[k], moore_o[k], cnt_o[k], sat_o[k],
                             exp_mealy[k], m_y(), avail[k], moore_m[k], cnt_m[k], cnt_m[k] == cmax[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_enable_gap();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
